// File: rtl/conv_in_stream_tx.sv
// ---------------------------------------------------------------------------
// conv_in_stream_tx
// Host-side transmitter for the conv accelerator input stream. Sends two IFMD
// halves and four kernel blocks (3x3 or 5x5) from a synchronous source RAM,
// framing each segment with a start strobe, then waits for the accelerator's
// result-start pulse before reporting done.
//
// Optional feature macro: CONV_TX_TIMEOUT_EN (out_st watchdog, sets o_err).
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous reset, active-low
//   i_start        1-cycle frame request (ignored while busy)
//   i_is_5x5_cfg   kernel size for the frame, sampled on accepted start
//   o_src_rd       source RAM read enable
//   o_src_addr     source RAM byte address
//   i_src_data     source RAM read data, valid the cycle after o_src_rd
//   o_in_st_ifmd   IFMD segment start strobe
//   o_in_st_kw     kernel segment start strobe
//   o_kw_is_5_5    kernel size level to receiver
//   o_din          data byte
//   i_out_st       result-start pulse from accelerator
//   o_busy         high from accepted start until done
//   o_done         1-cycle frame completion pulse
//   o_err          sticky watchdog flag (0 unless CONV_TX_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module conv_in_stream_tx #(
    parameter int unsigned IFMD_BYTES  = 64,
    parameter int unsigned AW          = 8,
    parameter int unsigned GAP_CYC     = 4
`ifdef CONV_TX_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_is_5x5_cfg,
    output logic          o_src_rd,
    output logic [AW-1:0] o_src_addr,
    input  logic [7:0]    i_src_data,
    output logic          o_in_st_ifmd,
    output logic          o_in_st_kw,
    output logic          o_kw_is_5_5,
    output logic [7:0]    o_din,
    input  logic          i_out_st,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned NMAX = (IFMD_BYTES > 25) ? IFMD_BYTES : 25;
    // headroom so the read-ahead compare (cnt + 3) cannot overflow
    localparam int unsigned CW   = $clog2(NMAX + 4);
    localparam int unsigned GW   = $clog2(GAP_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_STROBE, S_DATA, S_GAP, S_WAIT, S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_seg;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;
    logic            r_src_rd;
    logic [AW-1:0]   r_src_addr;
    logic            r_ifmd;
    logic            r_kw;
    logic            r_kw55;
    logic [7:0]      r_din;
    logic            r_busy;
    logic            r_done;

    logic [CW-1:0]   w_n;
    logic            w_last;
    logic            w_rd_more;

    // Segment base: two IFMD halves, then kernels on a fixed 25-byte stride
    function automatic logic [AW-1:0] f_base(input logic [2:0] s);
        logic [AW-1:0] b;
        case (s)
            3'd0:    b = '0;
            3'd1:    b = AW'(IFMD_BYTES);
            default: b = AW'(2 * IFMD_BYTES) + AW'(25) * AW'(s - 3'd2);
        endcase
        return b;
    endfunction

    // Segment length and data-phase control
    assign w_n       = (r_seg < 3'd2) ? CW'(IFMD_BYTES) : (r_kw55 ? CW'(25) : CW'(9));
    assign w_last    = (r_cnt == (w_n - CW'(1)));
    // while showing byte i, the read in flight for next cycle is byte i+3
    assign w_rd_more = ((r_cnt + CW'(3)) < w_n);

`ifdef CONV_TX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] r_to;
    logic          r_err;
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Frame sequencer; all outputs registered for the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_seg      <= '0;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_src_rd   <= 1'b0;
            r_src_addr <= '0;
            r_ifmd     <= 1'b0;
            r_kw       <= 1'b0;
            r_kw55     <= 1'b0;
            r_din      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef CONV_TX_TIMEOUT_EN
            r_to       <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= S_PRE;
                        r_seg      <= '0;
                        r_kw55     <= i_is_5x5_cfg;
                        r_busy     <= 1'b1;
                        r_src_rd   <= 1'b1;
                        r_src_addr <= f_base(3'd0);
`ifdef CONV_TX_TIMEOUT_EN
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_PRE: begin
                    r_state    <= S_STROBE;
                    r_ifmd     <= (r_seg < 3'd2);
                    r_kw       <= !(r_seg < 3'd2);
                    r_src_rd   <= 1'b1;
                    r_src_addr <= r_src_addr + AW'(1);
                end
                S_STROBE: begin
                    r_state    <= S_DATA;
                    r_ifmd     <= 1'b0;
                    r_kw       <= 1'b0;
                    r_din      <= i_src_data;
                    r_cnt      <= '0;
                    r_src_rd   <= (w_n > CW'(2));
                    r_src_addr <= r_src_addr + AW'(1);
                end
                S_DATA: begin
                    if (w_last) begin
                        r_state  <= S_GAP;
                        r_din    <= '0;
                        r_src_rd <= 1'b0;
                        r_gap    <= '0;
                    end else begin
                        r_din    <= i_src_data;
                        r_cnt    <= r_cnt + CW'(1);
                        r_src_rd <= w_rd_more;
                        if (w_rd_more) begin
                            r_src_addr <= r_src_addr + AW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        if (r_seg == 3'd5) begin
                            r_state <= S_WAIT;
`ifdef CONV_TX_TIMEOUT_EN
                            r_to    <= '0;
`endif
                        end else begin
                            r_state    <= S_PRE;
                            r_seg      <= r_seg + 3'd1;
                            r_src_rd   <= 1'b1;
                            r_src_addr <= f_base(r_seg + 3'd1);
                        end
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                S_WAIT: begin
                    // out_st wins over a watchdog expiry in the same cycle
                    if (i_out_st) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
`ifdef CONV_TX_TIMEOUT_EN
                    else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_to <= r_to + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_kw55  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_src_rd     = r_src_rd;
    assign o_src_addr   = r_src_addr;
    assign o_in_st_ifmd = r_ifmd;
    assign o_in_st_kw   = r_kw;
    assign o_kw_is_5_5  = r_kw55;
    assign o_din        = r_din;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
